uart_mmio_ctrl: RTL and testbench
=================================

# uart_mmio_ctrl

Memory-mapped controller that arbitrates CPU access to the UART and buffers traffic in both directions. It sits between the MIPS150 execute stage, which supplies the ALU address and the load/store strobes, and the UART's ready/valid ports. Transmit and receive FIFOs decouple the pipeline from serial timing. CPU loads of a status register replace busy-waiting on raw UART handshakes. An optional free-running cycle counter is mapped into the same I/O space.

## Interface
- FIFO_DEPTH, 8: entries per FIFO; power of two, ≥2.
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- stall  in  1  pipeline stall; when high, no CPU-side register or FIFO update.
- addr  in  32  byte address from the execute-stage ALU.
- we  in  1  store strobe, qualified by the CPU as a word/byte store.
- re  in  1  load strobe.
- wdata  in  8  store data, low byte of RT.
- rdata  out  32  load data, combinational from addr and current state.
- is_io  out  1  high when addr[31:28]==4'b1000.
- uart_din  out  8  TX FIFO head to the UART.
- uart_din_valid  out  1  TX FIFO not empty.
- uart_din_ready  in  1  UART accepts a byte.
- uart_dout  in  8  received byte from the UART.
- uart_dout_valid  in  1  received byte available.
- uart_dout_ready  out  1  RX FIFO not full.

## Operation
- Address decode uses addr[31:28]==4'b1000 and addr[5:2]. Accesses are acted on only when is_io is high.
  - 0x80000000 STATUS (R): bit0 tx_ready = TX not full; bit1 rx_valid = RX not empty; bit2 tx_drop sticky; bits[31:3]=0. Writing any value clears tx_drop.
  - 0x80000004 RX_DATA (R): {24'd0, RX head}. A read pops the RX FIFO.
  - 0x80000008 TX_DATA (W): pushes wdata into the TX FIFO.
  - 0x80000010 CYCLE (R): 32-bit cycle count.
  - 0x80000018 CYCLE_CLR (W): zeroes the counter.
  - Any other I/O address reads 0; writes to it are ignored.
- CPU side effects (push, pop, clear) occur only on an edge with stall low.
- TX FIFO:
  - Pushed by a CPU write. Popped when uart_din_valid & uart_din_ready.
  - A push while full is dropped and sets tx_drop.
  - Push and pop in the same cycle: occupancy is unchanged. When the FIFO is full, this case is accepted, not dropped.
- RX FIFO:
  - Pushed when uart_dout_valid & uart_dout_ready. Popped by a CPU read.
  - A read while empty returns 0 and does not pop.
  - Push and pop in the same cycle are both honoured. A push into an empty FIFO becomes visible in the next cycle.
- uart_din is 8'd0 while the TX FIFO is empty.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Occupancy uses a log2(FIFO_DEPTH)+1-bit count.

## Timing
- Reset with rst_n low at an edge:
  - both FIFOs empty, tx_drop=0, cycle counter=0;
  - resulting outputs: uart_din_valid=0, uart_din=0, uart_dout_ready=1;
  - STATUS reads 0x00000001.
- Reset asserted mid-transfer discards buffered bytes. The UART may lose an in-flight handshake; this is accepted.
- rdata is zero-latency combinational, sampled into the CPU's Y→Z register on the same edge that performs the pop.
- TX: a byte written at edge N appears on uart_din with valid high after edge N (the following cycle).
- RX: a byte accepted at edge N is readable via RX_DATA after edge N.
- Handshakes follow ready/valid rules: a transfer occurs on any edge where both signals are high. Valid never depends combinationally on ready.
- Cycle counter:
  - increments by 1 every edge with rst_n high, independent of stall, wrapping at 2^32;
  - CYCLE_CLR takes priority over the increment and loads 0 at that edge.

## Configuration
- UART_MMIO_CYCLE_COUNTER_EN:
  - Defined: the counter, CYCLE and CYCLE_CLR behave as above.
  - Undefined: no counter register is built; CYCLE reads 0 and CYCLE_CLR writes are ignored.
- FIFOs and STATUS are always built.

## Test plan
- Reset: hold rst_n=0 for 2 cycles → STATUS=0x1, uart_din_valid=0, uart_dout_ready=1, CYCLE=0.
- TX burst: write 0x41..0x48 to 0x80000008 with uart_din_ready=0 → STATUS bit0=0 after 8 writes. A 9th write (0x49) sets bit2. Raising ready drains 0x41..0x48 in order, with no 0x49.
- RX fill and read: drive 3 bytes 0x10, 0x20, 0x30 on uart_dout → RX_DATA reads return 0x10, 0x20, 0x30, then 0 with STATUS bit1=0.
- Stall gating: a TX_DATA write and an RX_DATA read issued with stall=1 → no push and no pop; the same access with stall=0 takes effect.
- Simultaneous: with TX full, issue a CPU push and a UART pop in one cycle → occupancy stays 8, tx_drop stays 0, and the new byte is last out.
- Counter (macro defined): after 100 cycles CYCLE=100. Write CYCLE_CLR → the next read is 1. Rebuild without the macro → CYCLE reads 0.

Source files
------------

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: STATUS/RX_DATA/TX_DATA registers with TX and RX FIFOs.
// Optional cycle counter (CYCLE / CYCLE_CLR) is built when UART_MMIO_CYCLE_COUNTER_EN is defined.
module uart_mmio_ctrl #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic        re,
  input  logic [7:0]  wdata,
  output logic [31:0] rdata,
  output logic        is_io,
  output logic [7:0]  uart_din,
  output logic        uart_din_valid,
  input  logic        uart_din_ready,
  input  logic [7:0]  uart_dout,
  input  logic        uart_dout_valid,
  output logic        uart_dout_ready
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [3:0] SEL_STATUS    = 4'h0;
  localparam logic [3:0] SEL_RX_DATA   = 4'h1;
  localparam logic [3:0] SEL_TX_DATA   = 4'h2;
  localparam logic [3:0] SEL_CYCLE     = 4'h4;
  localparam logic [3:0] SEL_CYCLE_CLR = 4'h6;

  logic [3:0]  sel;
  logic        cpu_ok;
  logic        unused_addr;

  logic [7:0]       tx_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic             tx_drop_q, tx_drop_d;
  logic             tx_full, tx_empty, tx_push_req, tx_push, tx_pop;

  logic [7:0]       rx_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic             rx_full, rx_empty, rx_push, rx_pop;
  logic [7:0]       rx_head;

  logic             status_clr;
  logic [31:0]      cycle_val;

  assign is_io       = (addr[31:28] == 4'b1000);
  assign sel         = addr[5:2];
  assign cpu_ok      = is_io & ~stall;
  assign unused_addr = ^{addr[27:6], addr[1:0]};

  // ---------------- TX FIFO ----------------
  assign tx_full        = (tx_cnt_q == CNT_W'(FIFO_DEPTH));
  assign tx_empty       = (tx_cnt_q == '0);
  assign uart_din_valid = ~tx_empty;
  assign uart_din       = tx_empty ? '0 : tx_mem_q[tx_rptr_q];
  assign tx_pop         = uart_din_valid & uart_din_ready;
  assign tx_push_req    = cpu_ok & we & (sel == SEL_TX_DATA);
  // A full FIFO still takes the push when a byte leaves on the same edge.
  assign tx_push        = tx_push_req & (~tx_full | tx_pop);
  assign status_clr     = cpu_ok & we & (sel == SEL_STATUS);

  always_comb begin
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    tx_drop_d = tx_drop_q;
    if (tx_push) tx_wptr_d = tx_wptr_q + PTR_W'(1);
    if (tx_pop)  tx_rptr_d = tx_rptr_q + PTR_W'(1);
    if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + CNT_W'(1);
    else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CNT_W'(1);
    if (tx_push_req && !tx_push) tx_drop_d = 1'b1;
    else if (status_clr)         tx_drop_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      tx_drop_q <= 1'b0;
    end else begin
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_drop_q <= tx_drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= wdata;
  end

  // ---------------- RX FIFO ----------------
  assign rx_full         = (rx_cnt_q == CNT_W'(FIFO_DEPTH));
  assign rx_empty        = (rx_cnt_q == '0);
  assign uart_dout_ready = ~rx_full;
  assign rx_push         = uart_dout_valid & uart_dout_ready;
  assign rx_pop          = cpu_ok & re & (sel == SEL_RX_DATA) & ~rx_empty;
  assign rx_head         = rx_empty ? '0 : rx_mem_q[rx_rptr_q];

  always_comb begin
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    rx_cnt_d  = rx_cnt_q;
    if (rx_push) rx_wptr_d = rx_wptr_q + PTR_W'(1);
    if (rx_pop)  rx_rptr_d = rx_rptr_q + PTR_W'(1);
    if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + CNT_W'(1);
    else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
    end else begin
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_cnt_q  <= rx_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wptr_q] <= uart_dout;
  end

  // ---------------- cycle counter ----------------
`ifdef UART_MMIO_CYCLE_COUNTER_EN
  logic [31:0] cycle_q, cycle_d;
  logic        cycle_clr;

  assign cycle_clr = cpu_ok & we & (sel == SEL_CYCLE_CLR);

  always_comb begin
    cycle_d = cycle_q + 32'd1;
    if (cycle_clr) cycle_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cycle_q <= '0;
    else        cycle_q <= cycle_d;
  end

  assign cycle_val = cycle_q;
`else
  assign cycle_val = '0;
`endif

  // ---------------- read mux ----------------
  always_comb begin
    rdata = '0;
    if (is_io) begin
      case (sel)
        SEL_STATUS:  rdata = {29'd0, tx_drop_q, ~rx_empty, ~tx_full};
        SEL_RX_DATA: rdata = {24'd0, rx_head};
        SEL_CYCLE:   rdata = cycle_val;
        default:     rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Self-checking bench for uart_mmio_ctrl: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_uart_mmio_ctrl;

  localparam int DEPTH = 8;
  localparam logic [31:0] A_STATUS = 32'h8000_0000;
  localparam logic [31:0] A_RXD    = 32'h8000_0004;
  localparam logic [31:0] A_TXD    = 32'h8000_0008;
  localparam logic [31:0] A_CYC    = 32'h8000_0010;
  localparam logic [31:0] A_CLR    = 32'h8000_0018;
  localparam logic [31:0] A_IDLE   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [31:0] addr;
  logic        we, re;
  logic [7:0]  wdata;
  logic [31:0] rdata;
  logic        is_io;
  logic [7:0]  uart_din;
  logic        uart_din_valid;
  logic        uart_din_ready;
  logic [7:0]  uart_dout;
  logic        uart_dout_valid;
  logic        uart_dout_ready;

  uart_mmio_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .addr(addr), .we(we), .re(re),
    .wdata(wdata), .rdata(rdata), .is_io(is_io),
    .uart_din(uart_din), .uart_din_valid(uart_din_valid), .uart_din_ready(uart_din_ready),
    .uart_dout(uart_dout), .uart_dout_valid(uart_dout_valid), .uart_dout_ready(uart_dout_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  drained[$];
  logic        m_drop;
  logic [31:0] m_cyc;

  logic [31:0] obs_rdata;
  logic        obs_din_valid;
  logic [7:0]  obs_din;
  logic        obs_dout_ready;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    logic [31:0] v;
    v = 32'd0;
    if (a[31:28] == 4'h8) begin
      case (a[5:2])
        4'h0: v = {29'd0, m_drop, rx_q.size() > 0, tx_q.size() < DEPTH};
        4'h1: v = (rx_q.size() > 0) ? {24'd0, rx_q[0]} : 32'd0;
`ifdef UART_MMIO_CYCLE_COUNTER_EN
        4'h4: v = m_cyc;
`endif
        default: v = 32'd0;
      endcase
    end
    return v;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; addr = A_IDLE; we = 1'b0; re = 1'b0; wdata = '0;
    uart_din_ready = 1'b0; uart_dout_valid = 1'b0; uart_dout = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tx_q.delete(); rx_q.delete(); m_drop = 1'b0; m_cyc = 32'd0;
  endtask

  // One bus cycle: drive, check outputs mid-cycle, clock, advance the model.
  task automatic do_cycle(input logic [31:0] a, input logic w, input logic r, input logic [7:0] wd,
                          input logic st, input logic dr, input logic dv, input logic [7:0] dd);
    logic io, tx_pop, tx_push, rx_push, rx_pop;
    logic [3:0] sel;
    logic [7:0] e_din;
    addr = a; we = w; re = r; wdata = wd; stall = st;
    uart_din_ready = dr; uart_dout_valid = dv; uart_dout = dd;
    #4;
    io    = (a[31:28] == 4'h8);
    sel   = a[5:2];
    e_din = (tx_q.size() > 0) ? tx_q[0] : 8'd0;
    chk("is_io", {31'd0, is_io}, {31'd0, io});
    chk("rdata", rdata, exp_rdata(a));
    chk("din_valid", {31'd0, uart_din_valid}, {31'd0, tx_q.size() > 0});
    chk("din", {24'd0, uart_din}, {24'd0, e_din});
    chk("dout_ready", {31'd0, uart_dout_ready}, {31'd0, rx_q.size() < DEPTH});
    obs_rdata = rdata; obs_din_valid = uart_din_valid; obs_din = uart_din;
    obs_dout_ready = uart_dout_ready;
    if (uart_din_valid && dr) drained.push_back(uart_din);
    tx_pop  = (tx_q.size() > 0) && dr;
    tx_push = io && !st && w && (sel == 4'h2);
    rx_push = dv && (rx_q.size() < DEPTH);
    rx_pop  = io && !st && r && (sel == 4'h1) && (rx_q.size() > 0);
    @(posedge clk);
    if (tx_pop) void'(tx_q.pop_front());
    if (tx_push) begin
      if (tx_q.size() < DEPTH) tx_q.push_back(wd);
      else m_drop = 1'b1;
    end
    if (io && !st && w && (sel == 4'h0)) m_drop = 1'b0;
    if (rx_pop) void'(rx_q.pop_front());
    if (rx_push) rx_q.push_back(dd);
    if (io && !st && w && (sel == 4'h6)) m_cyc = 32'd0;
    else m_cyc = m_cyc + 32'd1;
    #1;
  endtask

  task automatic idle(input logic dr);
    do_cycle(A_IDLE, 1'b0, 1'b0, 8'h00, 1'b0, dr, 1'b0, 8'h00);
  endtask

  logic [31:0] addr_tab [10];

  initial begin
    addr_tab[0] = A_STATUS; addr_tab[1] = A_RXD; addr_tab[2] = A_TXD; addr_tab[3] = A_CYC;
    addr_tab[4] = A_CLR; addr_tab[5] = 32'h8000_000C; addr_tab[6] = 32'h8000_0020;
    addr_tab[7] = 32'h1000_0008; addr_tab[8] = 32'h8ABC_0044; addr_tab[9] = 32'h8000_0014;

    // reset state
    do_reset();
    do_cycle(A_CYC, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("rst_cycle", obs_rdata, 32'd0);
    do_cycle(A_STATUS, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("rst_status", obs_rdata, 32'h1);
    chk("rst_din_valid", {31'd0, obs_din_valid}, 32'd0);
    chk("rst_din", {24'd0, obs_din}, 32'd0);
    chk("rst_dout_ready", {31'd0, obs_dout_ready}, 32'd1);

    // TX burst with overflow
    for (int i = 0; i < 8; i++)
      do_cycle(A_TXD, 1'b1, 1'b0, 8'(8'h41 + i), 1'b0, 1'b0, 1'b0, 8'h00);
    do_cycle(A_STATUS, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("tx_full_status", obs_rdata, 32'h0);
    do_cycle(A_TXD, 1'b1, 1'b0, 8'h49, 1'b0, 1'b0, 1'b0, 8'h00);
    do_cycle(A_STATUS, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("tx_drop_status", obs_rdata, 32'h4);
    drained.delete();
    repeat (10) idle(1'b1);
    chk("drain_count", drained.size(), 32'd8);
    for (int i = 0; i < 8 && i < drained.size(); i++)
      chk("drain_byte", {24'd0, drained[i]}, 32'h41 + i);
    do_cycle(A_STATUS, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00);
    do_cycle(A_STATUS, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("drop_cleared", obs_rdata, 32'h1);

    // RX fill and read
    do_cycle(A_IDLE, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h10);
    do_cycle(A_IDLE, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h20);
    do_cycle(A_IDLE, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h30);
    do_cycle(A_RXD, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("rx_rd0", obs_rdata, 32'h10);
    do_cycle(A_RXD, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("rx_rd1", obs_rdata, 32'h20);
    do_cycle(A_RXD, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("rx_rd2", obs_rdata, 32'h30);
    do_cycle(A_RXD, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("rx_rd_empty", obs_rdata, 32'h0);
    do_cycle(A_STATUS, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("rx_empty_status", obs_rdata, 32'h1);

    // stall gating
    do_cycle(A_TXD, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("stall_tx_nopush", {31'd0, uart_din_valid}, 32'd0);
    do_cycle(A_TXD, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("unstall_tx_push", {23'd0, uart_din_valid, uart_din}, 32'h15A);
    repeat (2) idle(1'b1);
    do_cycle(A_IDLE, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hC3);
    do_cycle(A_RXD, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    do_cycle(A_RXD, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("stall_rx_nopop", obs_rdata, 32'hC3);
    do_cycle(A_STATUS, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("unstall_rx_pop", obs_rdata, 32'h1);

    // simultaneous push/pop while TX full
    for (int i = 0; i < 8; i++)
      do_cycle(A_TXD, 1'b1, 1'b0, 8'(8'h41 + i), 1'b0, 1'b0, 1'b0, 8'h00);
    do_cycle(A_TXD, 1'b1, 1'b0, 8'h99, 1'b0, 1'b1, 1'b0, 8'h00);
    do_cycle(A_STATUS, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("simul_status", obs_rdata, 32'h0);
    drained.delete();
    repeat (10) idle(1'b1);
    chk("simul_count", drained.size(), 32'd8);
    if (drained.size() == 8) chk("simul_last", {24'd0, drained[7]}, 32'h99);

    // cycle counter
    do_reset();
    repeat (100) idle(1'b0);
    do_cycle(A_CYC, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
`ifdef UART_MMIO_CYCLE_COUNTER_EN
    chk("cycle_100", obs_rdata, 32'd100);
`else
    chk("cycle_off", obs_rdata, 32'd0);
`endif
    do_cycle(A_CLR, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(1'b0);
    do_cycle(A_CYC, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
`ifdef UART_MMIO_CYCLE_COUNTER_EN
    chk("cycle_after_clr", obs_rdata, 32'd1);
`else
    chk("cycle_after_clr_off", obs_rdata, 32'd0);
`endif

    // randomized traffic with varying UART pressure
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      int unsigned rp, vp;
      rp = (n / 250) % 4;
      vp = ((n / 250) + 1) % 4;
      a  = addr_tab[$urandom_range(0, 9)];
      if (n % 997 == 996) do_reset();
      do_cycle(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) < rp),
               ($urandom_range(0, 3) < vp), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout t=%0t", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
